// File: rtl/instr_fetch_link.sv
// Instruction fetch link: sends the PC over the UART, collects a two-byte reply (high byte first),
// and presents the 16-bit instruction. Each reply byte has a timeout, and retries are bounded.
module instr_fetch_link #(
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stall,
   input  logic [7:0]  address,
   input  logic        tx_done,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic [15:0] instr,
   output logic        done,
   output logic        error,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [3:0]    RETRY_LIM  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT_TX = 3'd2,
      WAIT_HI = 3'd3,
      WAIT_LO = 3'd4,
      DONE    = 3'd5,
      ERR     = 3'd6
   } state_t;

   state_t         state_q;
   logic [7:0]     addr_q;
   logic [7:0]     hi_q;
   logic [15:0]    instr_q;
   logic           pending_q;
   logic           tx_start_q;
   logic           done_q;
   logic           error_q;
   logic [3:0]     retry_q;
   logic [TW-1:0]  timer_q;

   logic           accept_d;
   logic           expired_d;
   logic           may_retry_d;
   logic [TW-1:0]  timer_d;

   // A request is taken either from this cycle's start or from one remembered while stalled.
   assign accept_d    = (pending_q | start) & ~stall;
   assign expired_d   = ~stall & ~rx_done & (timer_q == TIMER_LAST);
   assign may_retry_d = (retry_q < RETRY_LIM);
   assign timer_d     = stall ? timer_q : timer_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         hi_q       <= '0;
         instr_q    <= '0;
         pending_q  <= 1'b0;
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         retry_q    <= '0;
         timer_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  addr_q     <= address;
                  pending_q  <= 1'b0;
                  tx_start_q <= 1'b1;
                  state_q    <= SEND;
               end else if (start) begin
                  pending_q <= 1'b1;
               end
            end
            SEND: begin
               tx_start_q <= 1'b0;
               state_q    <= WAIT_TX;
            end
            WAIT_TX: begin
               if (tx_done) begin
                  timer_q <= '0;
                  state_q <= WAIT_HI;
               end
            end
            WAIT_HI, WAIT_LO: begin
               if (rx_done) begin
                  if (state_q == WAIT_HI) begin
                     hi_q    <= rx_data;
                     timer_q <= '0;
                     state_q <= WAIT_LO;
                  end else begin
                     instr_q <= {hi_q, rx_data};
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end else if (expired_d) begin
                  // Any partial high byte is discarded: the whole address is sent again.
                  if (may_retry_d) begin
                     retry_q    <= retry_q + 1'b1;
                     tx_start_q <= 1'b1;
                     state_q    <= SEND;
                  end else begin
                     error_q <= 1'b1;
                     state_q <= ERR;
                  end
               end else begin
                  timer_q <= timer_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               retry_q <= '0;
               state_q <= IDLE;
            end
            ERR: begin
               error_q <= 1'b0;
               retry_q <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = addr_q;
   assign instr    = instr_q;
   assign done     = done_q;
   assign error    = error_q;
   assign busy     = (state_q != IDLE);

endmodule
